// File: rtl/store_buffer_if.sv
// Bundles the store-enqueue, load-probe, drain and status signals of the store buffer.
// Store and drain channels are valid/ready: a beat transfers on a rising edge where both are high; the
// sender holds its payload stable while valid is high and ready is low. The load probe is a combinational query.
interface store_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int DATA_BYTES = DATA_W / 8;
   localparam int CNT_W      = $clog2(DEPTH + 1);

   logic                  st_valid_i;
   logic                  st_ready_o;
   logic [3:0]            st_op_i;
   logic [ADDR_W-1:0]     st_addr_i;
   logic [DATA_W-1:0]     st_data_i;

   logic                  ld_valid_i;
   logic [3:0]            ld_op_i;
   logic [ADDR_W-1:0]     ld_addr_i;
   logic                  ld_hit_o;
   logic                  ld_stall_o;
   logic [DATA_W-1:0]     ld_data_o;

   logic                  mem_valid_o;
   logic                  mem_ready_i;
   logic [ADDR_W-1:0]     mem_addr_o;
   logic [DATA_W-1:0]     mem_wdata_o;
   logic [DATA_BYTES-1:0] mem_wen_o;

   logic                  misalign_o;
   logic                  empty_o;
   logic                  full_o;
   logic [CNT_W-1:0]      count_o;

   modport slave (
      input  st_valid_i, st_op_i, st_addr_i, st_data_i,
      input  ld_valid_i, ld_op_i, ld_addr_i,
      input  mem_ready_i,
      output st_ready_o, ld_hit_o, ld_stall_o, ld_data_o,
      output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wen_o,
      output misalign_o, empty_o, full_o, count_o
   );

   modport master (
      output st_valid_i, st_op_i, st_addr_i, st_data_i,
      output ld_valid_i, ld_op_i, ld_addr_i,
      output mem_ready_i,
      input  st_ready_o, ld_hit_o, ld_stall_o, ld_data_o,
      input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wen_o,
      input  misalign_o, empty_o, full_o, count_o
   );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer: queues aligned stores, drains them oldest-first to data memory and
// forwards resident bytes to younger loads (youngest matching entry wins per byte lane).
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic clk,
   input logic rst_n,
   store_buffer_if.slave bus
);
   localparam int DATA_BYTES = DATA_W / 8;
   localparam int PTR_W      = $clog2(DEPTH);
   localparam int CNT_W      = $clog2(DEPTH + 1);

   // MEM_OP_t encoding shared with the decode stage.
   localparam logic [3:0] OP_LB  = 4'h0;
   localparam logic [3:0] OP_LH  = 4'h1;
   localparam logic [3:0] OP_LW  = 4'h2;
   localparam logic [3:0] OP_LBU = 4'h4;
   localparam logic [3:0] OP_LHU = 4'h5;
   localparam logic [3:0] OP_SB  = 4'h8;
   localparam logic [3:0] OP_SH  = 4'h9;
   localparam logic [3:0] OP_SW  = 4'hA;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_NONE} size_t;

   function automatic logic [DATA_BYTES-1:0] lane_mask(input size_t size, input logic [1:0] lo);
      lane_mask = '0;
      case (size)
         SZ_B:    lane_mask = DATA_BYTES'(1) << lo;
         SZ_H:    lane_mask = DATA_BYTES'(3) << {lo[1], 1'b0};
         SZ_W:    lane_mask = {DATA_BYTES{1'b1}};
         default: lane_mask = '0;
      endcase
   endfunction

   logic [ADDR_W-1:0]     e_addr  [DEPTH];
   logic [DATA_W-1:0]     e_data  [DEPTH];
   logic [DATA_BYTES-1:0] e_be    [DEPTH];
   logic [DEPTH-1:0]      e_valid;

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             misalign;

   size_t                 st_size, ld_size;
   logic                  st_mis, st_take, enq, pop;
   logic [DATA_W-1:0]     st_lane_data;
   logic [DATA_BYTES-1:0] st_be;

   always_comb begin
      st_size = SZ_NONE;
      case (bus.st_op_i)
         OP_SB:   st_size = SZ_B;
         OP_SH:   st_size = SZ_H;
         OP_SW:   st_size = SZ_W;
         default: st_size = SZ_NONE;
      endcase
      ld_size = SZ_NONE;
      case (bus.ld_op_i)
         OP_LB, OP_LBU: ld_size = SZ_B;
         OP_LH, OP_LHU: ld_size = SZ_H;
         OP_LW:         ld_size = SZ_W;
         default:       ld_size = SZ_NONE;
      endcase
   end

   always_comb begin
      st_mis = ((st_size == SZ_H) && bus.st_addr_i[0]) ||
               ((st_size == SZ_W) && (bus.st_addr_i[1:0] != 2'b00));
      st_be  = lane_mask(st_size, bus.st_addr_i[1:0]);
      st_lane_data = bus.st_data_i;
      case (st_size)
         SZ_B:    st_lane_data = {DATA_BYTES{bus.st_data_i[7:0]}};
         SZ_H:    st_lane_data = {(DATA_BYTES/2){bus.st_data_i[15:0]}};
         default: st_lane_data = bus.st_data_i;
      endcase
   end

   // A full buffer refuses stores outright, even when the head drains in the same cycle.
   assign st_take = bus.st_valid_i && bus.st_ready_o && (st_size != SZ_NONE);
   assign enq     = st_take && !st_mis;
   assign pop     = bus.mem_valid_o && bus.mem_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         e_valid  <= '0;
         misalign <= 1'b0;
      end else begin
         misalign <= st_take && st_mis;
         if (enq) begin
            e_valid[tail] <= 1'b1;
            tail          <= tail + PTR_W'(1);
         end
         if (pop) begin
            e_valid[head] <= 1'b0;
            head          <= head + PTR_W'(1);
         end
         case ({enq, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: e_valid alone decides residency.
   always_ff @(posedge clk) begin
      if (enq) begin
         e_addr[tail] <= {bus.st_addr_i[ADDR_W-1:2], 2'b00};
         e_data[tail] <= st_lane_data;
         e_be[tail]   <= st_be;
      end
   end

   assign bus.empty_o     = (count == '0);
   assign bus.full_o      = (count == CNT_W'(DEPTH));
   assign bus.st_ready_o  = !bus.full_o;
   assign bus.count_o     = count;
   assign bus.misalign_o  = misalign;
   assign bus.mem_valid_o = !bus.empty_o;
   assign bus.mem_addr_o  = e_addr[head];
   assign bus.mem_wdata_o = e_data[head];
   assign bus.mem_wen_o   = e_be[head];

   logic [DATA_BYTES-1:0] need, cov;
   logic [DATA_W-1:0]     fwd;
   logic [ADDR_W-1:0]     ld_word;
   logic [PTR_W-1:0]      idx;

   // Walk oldest to youngest so a younger matching entry overwrites an older one per lane.
   always_comb begin
      need    = lane_mask(ld_size, bus.ld_addr_i[1:0]);
      ld_word = {bus.ld_addr_i[ADDR_W-1:2], 2'b00};
      cov     = '0;
      fwd     = '0;
      idx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (e_valid[idx] && (e_addr[idx] == ld_word)) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
               if (e_be[idx][b] && need[b]) begin
                  cov[b]         = 1'b1;
                  fwd[b*8 +: 8]  = e_data[idx][b*8 +: 8];
               end
            end
         end
      end
   end

   assign bus.ld_hit_o   = bus.ld_valid_i && (need != '0) && (cov == need);
   assign bus.ld_stall_o = bus.ld_valid_i && (cov != '0) && (cov != need);
   assign bus.ld_data_o  = bus.ld_hit_o ? fwd : '0;

endmodule
